// File: rtl/bus_interconnect_if.sv
// Signal bundle between a FemtoRV32-style native-bus master, the interconnect and N peripheral slaves.
// The slave modport is the interconnect's view; the master modport is the view of whatever drives the CPU side and the peripherals.
interface bus_interconnect_if #(
    parameter int N_SLAVES = 4
);
    logic [31:0]             m_addr;
    logic [31:0]             m_wdata;
    logic [3:0]              m_wmask;
    logic                    m_rstrb;
    logic [31:0]             m_rdata;
    logic                    m_rbusy;
    logic                    m_wbusy;

    logic [31:0]             s_addr;
    logic [31:0]             s_wdata;
    logic [4*N_SLAVES-1:0]   s_wmask;
    logic [N_SLAVES-1:0]     s_rstrb;
    logic [32*N_SLAVES-1:0]  s_rdata;
    logic [N_SLAVES-1:0]     s_rvalid;
    logic [N_SLAVES-1:0]     s_wready;

    logic                    bus_err;
    logic [31:0]             err_addr;

    modport slave (
        input  m_addr, m_wdata, m_wmask, m_rstrb,
        output m_rdata, m_rbusy, m_wbusy,
        output s_addr, s_wdata, s_wmask, s_rstrb,
        input  s_rdata, s_rvalid, s_wready,
        output bus_err, err_addr
    );

    modport master (
        output m_addr, m_wdata, m_wmask, m_rstrb,
        input  m_rdata, m_rbusy, m_wbusy,
        input  s_addr, s_wdata, s_wmask, s_rstrb,
        output s_rdata, s_rvalid, s_wready,
        input  bus_err, err_addr
    );
endinterface

// File: rtl/bus_interconnect.sv
// One-master / N-slave interconnect: region decode on addr[31:28], per-slave strobes, wait states via
// slave handshakes, registered read return, timeout and bus-error reporting.
module bus_interconnect #(
    parameter int                    N_SLAVES   = 4,
    parameter logic [4*N_SLAVES-1:0] REGION_MAP = 16'h6540,
    parameter int                    TIMEOUT    = 16,
    parameter logic [31:0]           ERR_DATA   = 32'hDEAD_BEEF
) (
    input logic               clk,
    input logic               rst,
    bus_interconnect_if.slave bus
);
    localparam int IDX_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TIMER_LAST = TMR_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        WR_WAIT,
        ERR
    } state_t;

    state_t            state;
    logic [IDX_W-1:0]  idx_q;
    logic [31:0]       addr_q;
    logic [31:0]       wdata_q;
    logic [3:0]        mask_q;
    logic [TMR_W-1:0]  timer;
    logic [31:0]       rdata_q;
    logic [31:0]       err_addr_q;
    logic              rbusy_q;
    logic              wbusy_q;
    logic              bus_err_q;

    logic              hit;
    logic [IDX_W-1:0]  hit_idx;
    logic              wr_req;
    logic              rd_req;
    logic              hit_wready;
    logic              rsp_rvalid;
    logic              rsp_wready;
    logic [31:0]       rsp_rdata;

    logic [4*N_SLAVES-1:0] wmask_c;
    logic [N_SLAVES-1:0]   rstrb_c;
    logic [31:0]           s_addr_c;
    logic [31:0]           s_wdata_c;

    // NOTE: every signal written in a combinational block gets a default first, so no path can leave it unassigned and infer a latch.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        // Scanning downwards lets the lowest-numbered matching slave overwrite any higher one.
        for (int i = N_SLAVES - 1; i >= 0; i--) begin
            if (bus.m_addr[31:28] == REGION_MAP[4*i +: 4]) begin
                hit     = 1'b1;
                hit_idx = IDX_W'(i);
            end
        end
    end

    assign wr_req     = |bus.m_wmask;
    assign rd_req     = bus.m_rstrb & ~wr_req;
    assign hit_wready = bus.s_wready[hit_idx];
    assign rsp_rvalid = bus.s_rvalid[idx_q];
    assign rsp_wready = bus.s_wready[idx_q];
    assign rsp_rdata  = bus.s_rdata[{idx_q, 5'd0} +: 32];

    always_comb begin
        wmask_c   = '0;
        rstrb_c   = '0;
        s_addr_c  = {4'h0, bus.m_addr[27:0]};
        s_wdata_c = bus.m_wdata;
        if (state == IDLE) begin
            if (wr_req && hit) begin
                wmask_c[{hit_idx, 2'b00} +: 4] = bus.m_wmask;
            end else if (rd_req && hit) begin
                rstrb_c[hit_idx] = 1'b1;
            end
        end else begin
            s_addr_c  = {4'h0, addr_q[27:0]};
            s_wdata_c = wdata_q;
            if (state == WR_WAIT) begin
                wmask_c[{idx_q, 2'b00} +: 4] = mask_q;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            idx_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            mask_q     <= '0;
            timer      <= '0;
            rdata_q    <= '0;
            err_addr_q <= '0;
            rbusy_q    <= 1'b0;
            wbusy_q    <= 1'b0;
            bus_err_q  <= 1'b0;
        end else begin
            bus_err_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (wr_req) begin
                        if (!hit) begin
                            bus_err_q  <= 1'b1;
                            err_addr_q <= bus.m_addr;
                        end else begin
                            idx_q   <= hit_idx;
                            addr_q  <= bus.m_addr;
                            wdata_q <= bus.m_wdata;
                            mask_q  <= bus.m_wmask;
                            timer   <= '0;
                            if (!hit_wready) begin
                                state   <= WR_WAIT;
                                wbusy_q <= 1'b1;
                            end
                        end
                    end else if (rd_req) begin
                        idx_q   <= hit_idx;
                        addr_q  <= bus.m_addr;
                        timer   <= '0;
                        rbusy_q <= 1'b1;
                        state   <= hit ? RD_WAIT : ERR;
                    end
                end

                RD_WAIT: begin
                    // A response in the expiry cycle still wins over the timeout.
                    if (rsp_rvalid) begin
                        rdata_q <= rsp_rdata;
                        rbusy_q <= 1'b0;
                        state   <= IDLE;
                    end else if (timer == TIMER_LAST) begin
                        rdata_q    <= ERR_DATA;
                        rbusy_q    <= 1'b0;
                        bus_err_q  <= 1'b1;
                        err_addr_q <= addr_q;
                        state      <= IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                WR_WAIT: begin
                    if (rsp_wready) begin
                        wbusy_q <= 1'b0;
                        state   <= IDLE;
                    end else if (timer == TIMER_LAST) begin
                        wbusy_q    <= 1'b0;
                        bus_err_q  <= 1'b1;
                        err_addr_q <= addr_q;
                        state      <= IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                ERR: begin
                    rdata_q    <= ERR_DATA;
                    rbusy_q    <= 1'b0;
                    bus_err_q  <= 1'b1;
                    err_addr_q <= addr_q;
                    state      <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign bus.m_rdata  = rdata_q;
    assign bus.m_rbusy  = rbusy_q;
    assign bus.m_wbusy  = wbusy_q;
    assign bus.s_addr   = s_addr_c;
    assign bus.s_wdata  = s_wdata_c;
    assign bus.s_wmask  = wmask_c;
    assign bus.s_rstrb  = rstrb_c;
    assign bus.bus_err  = bus_err_q;
    assign bus.err_addr = err_addr_q;
endmodule

// File: tb/tb_bus_interconnect.sv
// Transaction-level bench for bus_interconnect: each access's expected cycle-by-cycle outputs come from
// the decode/latency/timeout rules, compared every cycle, plus literal checks on the directed scenarios.
module tb_bus_interconnect;
    localparam int          N    = 4;
    localparam int          TMO  = 16;
    localparam logic [31:0] ERRD = 32'hDEAD_BEEF;
    localparam logic [15:0] RMAP = 16'h6540;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bus_interconnect_if #(.N_SLAVES(N)) bus ();

    bus_interconnect #(
        .N_SLAVES  (N),
        .REGION_MAP(RMAP),
        .TIMEOUT   (TMO),
        .ERR_DATA  (ERRD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic           rbusy;
        logic           wbusy;
        logic           berr;
        logic [31:0]    rdata;
        logic [31:0]    eaddr;
        logic [N-1:0]   rstrb;
        logic [4*N-1:0] wmask;
        bit             saddr_v;
        logic [31:0]    saddr;
        bit             swdata_v;
        logic [31:0]    swdata;
    } exp_t;

    exp_t        ex;
    bit          chk_en = 1'b0;
    int          checks = 0;
    int          errors = 0;

    logic [31:0] mdl_rdata;
    logic [31:0] mdl_eaddr;
    bit          pend_berr;

    int          busy_seen, strobe_seen, wm_seen, berr_seen;
    logic [31:0] saddr_k1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at t=%0t: got 0x%0h, expected 0x%0h", name, $time, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("m_rbusy",  64'(bus.m_rbusy),  64'(ex.rbusy));
            check("m_wbusy",  64'(bus.m_wbusy),  64'(ex.wbusy));
            check("bus_err",  64'(bus.bus_err),  64'(ex.berr));
            check("m_rdata",  64'(bus.m_rdata),  64'(ex.rdata));
            check("err_addr", 64'(bus.err_addr), 64'(ex.eaddr));
            check("s_rstrb",  64'(bus.s_rstrb),  64'(ex.rstrb));
            check("s_wmask",  64'(bus.s_wmask),  64'(ex.wmask));
            if (ex.saddr_v)  check("s_addr",  64'(bus.s_addr),  64'(ex.saddr));
            if (ex.swdata_v) check("s_wdata", 64'(bus.s_wdata), 64'(ex.swdata));
        end
    end

    // Region table lookup: first slave whose region equals addr[31:28], or -1.
    function automatic int decode(input logic [31:0] a);
        logic [4*N-1:0] rm;
        rm = RMAP;
        for (int i = 0; i < N; i++) begin
            if (a[31:28] == rm[4*i +: 4]) return i;
        end
        return -1;
    endfunction

    task automatic cyc_begin();
        @(posedge clk);
        #1;
    endtask

    task automatic cyc_end();
        @(negedge clk);
        busy_seen   += int'(bus.m_rbusy | bus.m_wbusy);
        strobe_seen += int'(|bus.s_rstrb);
        wm_seen     += int'(|bus.s_wmask);
        berr_seen   += int'(bus.bus_err);
    endtask

    task automatic drive_slaves(input int sel, input bit rv, input bit wr);
        for (int i = 0; i < N; i++) bus.s_rdata[32*i +: 32] = $urandom;
        bus.s_rvalid = N'($urandom);
        bus.s_wready = N'($urandom);
        if (sel >= 0) begin
            bus.s_rvalid[sel] = rv;
            bus.s_wready[sel] = wr;
        end
    endtask

    task automatic idle_cycle(input logic [N-1:0] force_rv);
        cyc_begin();
        rst         = 1'b0;
        bus.m_addr  = $urandom;
        bus.m_wdata = $urandom;
        bus.m_wmask = 4'h0;
        bus.m_rstrb = 1'b0;
        drive_slaves(-1, 1'b0, 1'b0);
        bus.s_rvalid = bus.s_rvalid | force_rv;
        ex.rbusy    = 1'b0;
        ex.wbusy    = 1'b0;
        ex.berr     = pend_berr;
        ex.rdata    = mdl_rdata;
        ex.eaddr    = mdl_eaddr;
        ex.rstrb    = '0;
        ex.wmask    = '0;
        ex.saddr_v  = 1'b1;
        ex.saddr    = {4'h0, bus.m_addr[27:0]};
        ex.swdata_v = 1'b1;
        ex.swdata   = bus.m_wdata;
        pend_berr   = 1'b0;
        cyc_end();
    endtask

    // One access: request cycle, wait cycles with noise, then the completion cycle.
    // lat = cycle (after the request) at which the addressed slave responds; rst_at = wait cycle to assert rst, -1 for none.
    task automatic run_txn(input logic [31:0] addr, input logic [3:0] mask, input bit rd, input int lat,
                           input int rst_at, input bit use_val, input logic [31:0] val);
        int          s;
        int          done;
        bit          is_wr, is_rd, err, aborted;
        logic [31:0] wd, got;
        logic [4*N-1:0] wm;
        s       = decode(addr);
        is_wr   = (mask != 4'h0);
        is_rd   = rd && !is_wr;
        wd      = $urandom;
        got     = '0;
        aborted = 1'b0;
        if (s < 0) done = is_wr ? 0 : 1;
        else       done = (lat < TMO) ? lat : TMO;
        err = (s < 0) || (lat > TMO);
        wm  = '0;
        if (is_wr && s >= 0) wm[4*s +: 4] = mask;
        busy_seen = 0; strobe_seen = 0; wm_seen = 0; berr_seen = 0;

        cyc_begin();
        bus.m_addr  = addr;
        bus.m_wdata = wd;
        bus.m_wmask = mask;
        bus.m_rstrb = rd;
        drive_slaves(s, 1'b0, is_wr && lat == 0);
        ex.rbusy    = 1'b0;
        ex.wbusy    = 1'b0;
        ex.berr     = 1'b0;
        ex.rdata    = mdl_rdata;
        ex.eaddr    = mdl_eaddr;
        ex.rstrb    = '0;
        if (is_rd && s >= 0) ex.rstrb[s] = 1'b1;
        ex.wmask    = wm;
        ex.saddr_v  = 1'b1;
        ex.saddr    = {4'h0, addr[27:0]};
        ex.swdata_v = 1'b1;
        ex.swdata   = wd;
        cyc_end();

        for (int k = 1; k <= done; k++) begin
            cyc_begin();
            bus.m_addr  = $urandom;
            bus.m_wdata = $urandom;
            bus.m_wmask = ($urandom_range(3) == 0) ? 4'($urandom) : 4'h0;
            bus.m_rstrb = ($urandom_range(3) == 0);
            drive_slaves(s, is_rd && k == lat, is_wr && k == lat);
            if (is_rd && s >= 0 && k == lat) begin
                if (use_val) bus.s_rdata[32*s +: 32] = val;
                got = bus.s_rdata[32*s +: 32];
            end
            if (k == rst_at) rst = 1'b1;
            ex.rbusy    = is_rd;
            ex.wbusy    = is_wr;
            ex.berr     = 1'b0;
            ex.rstrb    = '0;
            ex.wmask    = wm;
            ex.saddr_v  = (s >= 0);
            ex.saddr    = {4'h0, addr[27:0]};
            ex.swdata_v = is_wr;
            ex.swdata   = wd;
            cyc_end();
            if (k == 1) saddr_k1 = bus.s_addr;
            if (k == rst_at) begin
                aborted = 1'b1;
                break;
            end
        end

        if (aborted) begin
            mdl_rdata = '0;
            mdl_eaddr = '0;
            pend_berr = 1'b0;
            idle_cycle((s >= 0) ? (N'(1) << s) : '0);
        end else begin
            if (is_rd) mdl_rdata = err ? ERRD : got;
            if (err) begin
                mdl_eaddr = addr;
                pend_berr = 1'b1;
            end
            idle_cycle('0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        logic [3:0]  m;
        bit          r;
        int          lat, ra;

        rst          = 1'b1;
        bus.m_addr   = '0;
        bus.m_wdata  = '0;
        bus.m_wmask  = '0;
        bus.m_rstrb  = 1'b0;
        bus.s_rdata  = '0;
        bus.s_rvalid = '0;
        bus.s_wready = '0;
        mdl_rdata    = '0;
        mdl_eaddr    = '0;
        pend_berr    = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset m_rbusy",  64'(bus.m_rbusy),  64'h0);
        check("reset m_wbusy",  64'(bus.m_wbusy),  64'h0);
        check("reset bus_err",  64'(bus.bus_err),  64'h0);
        check("reset m_rdata",  64'(bus.m_rdata),  64'h0);
        check("reset err_addr", 64'(bus.err_addr), 64'h0);
        check("reset s_rstrb",  64'(bus.s_rstrb),  64'h0);
        check("reset s_wmask",  64'(bus.s_wmask),  64'h0);

        chk_en = 1'b1;
        idle_cycle('0);
        idle_cycle('0);

        run_txn(32'h0000_0010, 4'h0, 1'b1, 1, -1, 1'b1, 32'h1234_5678);
        check("rd0 m_rdata",     64'(bus.m_rdata), 64'h1234_5678);
        check("rd0 busy cycles", 64'(busy_seen),   64'd1);
        check("rd0 strobe",      64'(strobe_seen), 64'd1);
        idle_cycle('0);

        run_txn(32'h4000_0004, 4'hF, 1'b0, 3, -1, 1'b0, '0);
        check("wr1 wbusy cycles", 64'(busy_seen), 64'd3);
        check("wr1 wmask cycles", 64'(wm_seen),   64'd4);
        check("wr1 s_addr",       64'(saddr_k1),  64'h0000_0004);
        check("wr1 bus_err",      64'(berr_seen), 64'd0);
        idle_cycle('0);

        run_txn(32'h9000_0000, 4'h0, 1'b1, 1, -1, 1'b0, '0);
        check("unmapped m_rdata",  64'(bus.m_rdata),  64'hDEAD_BEEF);
        check("unmapped err_addr", 64'(bus.err_addr), 64'h9000_0000);
        check("unmapped bus_err",  64'(berr_seen),    64'd1);
        check("unmapped strobe",   64'(strobe_seen),  64'd0);
        idle_cycle('0);

        run_txn(32'h5000_0000, 4'h0, 1'b1, TMO + 10, -1, 1'b0, '0);
        check("timeout rbusy cycles", 64'(busy_seen),    64'd16);
        check("timeout m_rdata",      64'(bus.m_rdata),  64'hDEAD_BEEF);
        check("timeout err_addr",     64'(bus.err_addr), 64'h5000_0000);
        check("timeout bus_err",      64'(berr_seen),    64'd1);
        idle_cycle('0);

        run_txn(32'h4000_0000, 4'h3, 1'b1, 1, -1, 1'b0, '0);
        check("rd+wr strobe",  64'(strobe_seen), 64'd0);
        check("rd+wr bus_err", 64'(berr_seen),   64'd0);
        check("rd+wr wbusy",   64'(busy_seen),   64'd1);
        idle_cycle('0);

        run_txn(32'h0000_0020, 4'h0, 1'b1, TMO + 10, 3, 1'b0, '0);
        check("rst m_rbusy",  64'(bus.m_rbusy),  64'h0);
        check("rst m_rdata",  64'(bus.m_rdata),  64'h0);
        check("rst err_addr", 64'(bus.err_addr), 64'h0);
        idle_cycle('0);
        check("rst late rsp m_rdata", 64'(bus.m_rdata), 64'h0);

        for (int t = 0; t < 300; t++) begin
            a = $urandom;
            case ($urandom_range(4))
                0:       a[31:28] = 4'h0;
                1:       a[31:28] = 4'h4;
                2:       a[31:28] = 4'h5;
                3:       a[31:28] = 4'h6;
                default: a[31:28] = a[31:28];
            endcase
            if ($urandom_range(1) == 1) begin
                m = 4'($urandom_range(15, 1));
                r = ($urandom_range(3) == 0);
            end else begin
                m = 4'h0;
                r = 1'b1;
            end
            lat = int'($urandom_range(TMO + 2));
            if (m == 4'h0 && lat == 0) lat = 1;
            ra = ($urandom_range(19) == 0) ? int'($urandom_range(3, 1)) : -1;
            run_txn(a, m, r, lat, ra, 1'b0, '0);
            repeat ($urandom_range(2)) idle_cycle('0);
        end

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
